csa_wide_seq: RTL and testbench

Multi-precision add/subtract sequencer that drives the team's 16-bit carry-select adder slice. It accepts wide operands over a valid/ready handshake and feeds the adder one 16-bit slice per cycle, least-significant first. It chains each slice's carry-out into the next slice's carry-in through a register. It then collects the slice sums and presents the full result downstream with carry-out and a signed-overflow flag.

---
 rtl/csa_wide_seq.sv | 160 ++++++++++++++++
 tb/tb_csa_wide_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_wide_seq.sv
// rtl/csa_wide_seq.sv - multi-precision add/subtract sequencer for a 16-bit carry-select adder slice
//
// Purpose: accepts W-bit operands (W = 16*WORDS) over a valid/ready handshake,
// walks them through an external 16-bit adder one slice per cycle (LSB slice
// first) with a registered carry chain, then presents the full result with
// carry-out and a signed-overflow flag until the downstream accepts it.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand request handshake
//   in_a, in_b            W-bit operands
//   in_cin                carry-in for add (ignored for subtract)
//   in_sub                1 = A - B, 0 = A + B + in_cin
//   out_valid/out_ready   result handshake
//   out_sum               W-bit result
//   out_cout              final carry-out (subtract: 1 = no borrow)
//   out_ovf               two's-complement signed overflow
//   csa_a, csa_b, csa_cin slice operands and carry-in driven to the adder
//   csa_sum, csa_cout     adder result, combinational in the same cycle

module csa_wide_seq #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   in_a,
   input  logic [16*WORDS-1:0]   in_b,
   input  logic                  in_cin,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   out_sum,
   output logic                  out_cout,
   output logic                  out_ovf,
   output logic [15:0]           csa_a,
   output logic [15:0]           csa_b,
   output logic                  csa_cin,
   input  logic [15:0]           csa_sum,
   input  logic                  csa_cout
);

   localparam int W  = 16 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;        // B already inverted for subtract
   logic [W-1:0]    r_sum;
   logic            r_carry;
   logic            r_cout;
   logic            r_ovf;
   logic [IW-1:0]   r_idx;

   logic            w_accept;
   logic            w_last;
   logic [IW+3:0]   w_base;     // bit offset of the current slice

   assign w_base    = {r_idx, 4'b0000};
   assign w_last    = (r_idx == LAST_IDX);

   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      csa_a       = '0;
      csa_b       = '0;
      csa_cin     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            csa_a   = r_a[w_base +: 16];
            csa_b   = r_b[w_base +: 16];
            csa_cin = r_carry;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // in_ready only returns after the state register leaves DONE,
            // so there is no same-cycle accept of a new request here.
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= in_a;
                  // Subtract is A + ~B + 1, so the +1 rides in on the carry.
                  r_b     <= in_sub ? ~in_b : in_b;
                  r_carry <= in_sub ? 1'b1 : in_cin;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_sum[w_base +: 16] <= csa_sum;
               r_carry             <= csa_cout;
               if (w_last) begin
                  r_cout <= csa_cout;
                  // Overflow: operand signs agree but the result sign differs.
                  r_ovf  <= (r_a[W-1] == r_b[W-1]) && (csa_sum[15] != r_a[W-1]);
                  r_idx  <= '0;
               end else begin
                  r_idx  <= r_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_wide_seq.sv
// tb/tb_csa_wide_seq.sv - self-checking bench for csa_wide_seq with a 16-bit adder model

module tb_csa_wide_seq;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic [15:0]   csa_a;
   logic [15:0]   csa_b;
   logic          csa_cin;
   logic [15:0]   csa_sum;
   logic          csa_cout;

   int            n_vec;
   int            n_err;
   int            cyc;
   logic          chk_on;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] bp;
      logic         c0;
      int           acc;
   } req_t;

   req_t          q[$];

   csa_wide_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .csa_a     (csa_a),
      .csa_b     (csa_b),
      .csa_cin   (csa_cin),
      .csa_sum   (csa_sum),
      .csa_cout  (csa_cout)
   );

   // Behavioural 16-bit adder slice
   assign {csa_cout, csa_sum} = {1'b0, csa_a} + {1'b0, csa_b} + {16'd0, csa_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Model: whole-word arithmetic on the queued request, checked every cycle
   always @(negedge clk) begin
      logic         exp_rdy;
      logic         exp_vld;
      int           k;
      logic [W:0]   full;
      logic [W:0]   mask;
      logic [W:0]   low;
      logic [W-1:0] sh;
      if (chk_on) begin
         if (q.size() == 0) begin
            exp_rdy = 1'b1;
            exp_vld = 1'b0;
            k       = -1;
         end else begin
            k       = cyc - q[0].acc;
            exp_rdy = 1'b0;
            exp_vld = (k >= WORDS);
         end
         check("in_ready", W'(in_ready), W'(exp_rdy));
         check("out_valid", W'(out_valid), W'(exp_vld));
         if (exp_vld) begin
            full = {1'b0, q[0].a} + {1'b0, q[0].bp} + {{W{1'b0}}, q[0].c0};
            check("out_sum", out_sum, full[W-1:0]);
            check("out_cout", W'(out_cout), W'(full[W]));
            check("out_ovf", W'(out_ovf),
                  W'((q[0].a[W-1] == q[0].bp[W-1]) && (full[W-1] != q[0].a[W-1])));
         end
         if (q.size() > 0 && k >= 0 && k < WORDS) begin
            sh = q[0].a >> (16 * k);
            check("csa_a", W'(csa_a), W'(sh[15:0]));
            sh = q[0].bp >> (16 * k);
            check("csa_b", W'(csa_b), W'(sh[15:0]));
            mask = ((W+1)'(1) << (16 * k)) - 1'b1;
            low  = ({1'b0, q[0].a} & mask) + ({1'b0, q[0].bp} & mask) + {{W{1'b0}}, q[0].c0};
            check("csa_cin", W'(csa_cin), W'(low[16 * k]));
         end else begin
            check("csa_idle", {csa_cin, csa_b, csa_a}, '0);
         end
         if (rst) begin
            q.delete();
         end else begin
            if (exp_vld && out_ready) void'(q.pop_front());
            if (exp_rdy && in_valid)
               q.push_back('{a: in_a, bp: (in_sub ? ~in_b : in_b),
                             c0: (in_sub ? 1'b1 : in_cin), acc: cyc + 1});
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] es, input logic ec,
                        input logic eo, input logic release_it);
      int n;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            check("accept_timeout", W'(in_ready), W'(1));
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         n++;
         if (n > 50) break;
      end
      check("latency", W'(n), W'(WORDS));
      check("lit_sum", out_sum, es);
      check("lit_cout", W'(out_cout), W'(ec));
      check("lit_ovf", W'(out_ovf), W'(eo));
      if (release_it) begin
         @(posedge clk); #1 out_ready = 1'b1;
         @(posedge clk); #1 out_ready = 1'b0;
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; chk_on = 1'b0;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
      in_sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_sum", out_sum, '0);
      check("rst_flags", W'({out_cout, out_ovf}), W'(0));
      check("rst_csa", {csa_cin, csa_b, csa_a}, '0);
      chk_on = 1'b1;
      @(posedge clk); #1;

      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
      do_op(64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
      do_op(64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0, 1'b1);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
      do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1);

      // Backpressure with a second request held upstream
      do_op(64'h10, 64'h20, 1'b1, 1'b0, 64'h31, 1'b0, 1'b0, 1'b0);
      in_a = 64'h100; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("bp_in_ready", W'(in_ready), W'(0));
         check("bp_sum", out_sum, 64'h31);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_after", W'(in_ready), W'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      begin
         int n;
         n = 0;
         forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) break;
         end
         check("bp_latency", W'(n), W'(WORDS));
         check("bp_held_sum", out_sum, 64'hFF);
         check("bp_held_cout", W'(out_cout), W'(1));
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;

      // Reset while the third slice (idx 2) is in the adder
      in_a = 64'h9999_8888_7777_6666; in_b = 64'h1111; in_cin = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", W'(in_ready), W'(1));
      check("abort_out_valid", W'(out_valid), W'(0));
      repeat (6) begin
         @(negedge clk);
         check("abort_no_valid", W'(out_valid), W'(0));
      end
      @(posedge clk); #1;
      do_op(64'h1234, 64'h1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
